// File: rtl/int_issue_queue_if.sv
// Dispatch/issue bundle between the decode stage, the integer issue queue and the integer ALU.
// The queue takes the slave side; the decoder/ALU side (or a bench) takes the master side.
interface int_issue_queue_if #(
    parameter int unsigned PTR_W = 2
);
    logic             Dispatch_en_Int;
    logic [3:0]       Dispatch_Opcode;
    logic [4:0]       Dispatch_Shfamt;
    logic [31:0]      Dispatch_Imm_LS;
    logic             Queue_Full;
    logic [PTR_W:0]   Queue_Count;
    logic             Overflow_Err;
    logic             Issue_Valid;
    logic [3:0]       Issue_Opcode;
    logic [4:0]       Issue_Shfamt;
    logic [31:0]      Issue_Imm;
    logic             Issue_Ready;

    modport master (
        output Dispatch_en_Int, Dispatch_Opcode, Dispatch_Shfamt, Dispatch_Imm_LS, Issue_Ready,
        input  Queue_Full, Queue_Count, Overflow_Err, Issue_Valid, Issue_Opcode, Issue_Shfamt,
               Issue_Imm
    );

    modport slave (
        input  Dispatch_en_Int, Dispatch_Opcode, Dispatch_Shfamt, Dispatch_Imm_LS, Issue_Ready,
        output Queue_Full, Queue_Count, Overflow_Err, Issue_Valid, Issue_Opcode, Issue_Shfamt,
               Issue_Imm
    );
endinterface

// File: rtl/int_issue_queue.sv
// In-order issue FIFO between the decoder and the integer ALU: captures dispatched instructions,
// presents the head entry over valid/ready and reports full/occupancy back to dispatch.
module int_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input logic               Clk,
    input logic               Rst,
    input logic               Flush,
    int_issue_queue_if.slave  q
);
    localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

    logic [3:0]       opcode_mem [DEPTH];
    logic [4:0]       shfamt_mem [DEPTH];
    logic [31:0]      imm_mem    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;

    logic full;
    logic empty;
    logic do_write;
    logic do_pop;

    // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot for a write.
    assign full     = (count_q == FullCount);
    assign empty    = (count_q == '0);
    assign do_write = q.Dispatch_en_Int && !full;
    assign do_pop   = !empty && q.Issue_Ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (q.Dispatch_en_Int && full);
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({do_write, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry payload carries no reset; validity is tracked solely by count.
    always_ff @(posedge Clk) begin
        if (!Rst && !Flush && do_write) begin
            opcode_mem[wr_ptr_q] <= q.Dispatch_Opcode;
            shfamt_mem[wr_ptr_q] <= q.Dispatch_Shfamt;
            imm_mem[wr_ptr_q]    <= q.Dispatch_Imm_LS;
        end
    end

    always_comb begin
        q.Queue_Full   = full;
        q.Queue_Count  = count_q;
        q.Overflow_Err = overflow_q;
        q.Issue_Valid  = !empty;
        q.Issue_Opcode = '0;
        q.Issue_Shfamt = '0;
        q.Issue_Imm    = '0;
        if (!empty) begin
            q.Issue_Opcode = opcode_mem[rd_ptr_q];
            q.Issue_Shfamt = shfamt_mem[rd_ptr_q];
            q.Issue_Imm    = imm_mem[rd_ptr_q];
        end
    end

    count_bound_a: assert property (@(posedge Clk) disable iff (Rst) count_q <= FullCount);
    ptr_count_a: assert property (@(posedge Clk) disable iff (Rst)
        PTR_W'(wr_ptr_q - rd_ptr_q) == count_q[PTR_W-1:0]);
endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue: hand-computed expectations for ordering, full/overflow,
// wrap-around under steady flow, flush and reset priority.
module tb_int_issue_queue;
    logic Clk;
    logic Rst;
    logic Flush;
    int   checks;
    int   errors;

    int_issue_queue_if #(.PTR_W(2)) bus ();

    int_issue_queue #(
        .DEPTH(4),
        .PTR_W(2)
    ) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .Flush(Flush),
        .q    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [4:0] sh, input logic [31:0] imm);
        bus.Dispatch_en_Int = 1'b1;
        bus.Dispatch_Opcode = op;
        bus.Dispatch_Shfamt = sh;
        bus.Dispatch_Imm_LS = imm;
        tick();
        bus.Dispatch_en_Int = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [3:0] op, input logic [31:0] imm);
        check({tag, "_valid"}, 32'(bus.Issue_Valid), 32'd1);
        check({tag, "_op"}, 32'(bus.Issue_Opcode), 32'(op));
        check({tag, "_imm"}, bus.Issue_Imm, imm);
        bus.Issue_Ready = 1'b1;
        tick();
        bus.Issue_Ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Rst = 1'b1;
        Flush = 1'b0;
        bus.Dispatch_en_Int = 1'b0;
        bus.Dispatch_Opcode = '0;
        bus.Dispatch_Shfamt = '0;
        bus.Dispatch_Imm_LS = '0;
        bus.Issue_Ready = 1'b0;
        tick();
        tick();
        Rst = 1'b0;
        check("rst_count", 32'(bus.Queue_Count), 32'd0);
        check("rst_full", 32'(bus.Queue_Full), 32'd0);
        check("rst_valid", 32'(bus.Issue_Valid), 32'd0);
        check("rst_ovf", 32'(bus.Overflow_Err), 32'd0);
        check("rst_op", 32'(bus.Issue_Opcode), 32'd0);

        // 1: single ADD, not visible in its own write cycle
        bus.Dispatch_en_Int = 1'b1;
        bus.Dispatch_Opcode = 4'h2;
        bus.Dispatch_Shfamt = 5'd0;
        bus.Dispatch_Imm_LS = 32'h5;
        #1;
        check("t1_nobypass", 32'(bus.Issue_Valid), 32'd0);
        tick();
        bus.Dispatch_en_Int = 1'b0;
        check("t1_count", 32'(bus.Queue_Count), 32'd1);
        pop_check("t1", 4'h2, 32'h5);
        check("t1_empty", 32'(bus.Queue_Count), 32'd0);

        // 2: fill with ADD, SUB, SLL(3), SRL then drain in order
        push(4'h2, 5'd0, 32'h10);
        push(4'h6, 5'd0, 32'h11);
        push(4'h8, 5'd3, 32'h12);
        push(4'h9, 5'd0, 32'h13);
        check("t2_full", 32'(bus.Queue_Full), 32'd1);
        check("t2_count", 32'(bus.Queue_Count), 32'd4);
        pop_check("t2_e0", 4'h2, 32'h10);
        pop_check("t2_e1", 4'h6, 32'h11);
        check("t2_shfamt", 32'(bus.Issue_Shfamt), 32'd3);
        pop_check("t2_e2", 4'h8, 32'h12);
        pop_check("t2_e3", 4'h9, 32'h13);
        check("t2_count_end", 32'(bus.Queue_Count), 32'd0);
        check("t2_valid_end", 32'(bus.Issue_Valid), 32'd0);

        // 3: overflow while full
        for (int i = 0; i < 4; i++) push(4'(i + 1), 5'd0, 32'h20 + 32'(i));
        check("t3_ovf_before", 32'(bus.Overflow_Err), 32'd0);
        push(4'hC, 5'd0, 32'hDEAD);
        check("t3_ovf", 32'(bus.Overflow_Err), 32'd1);
        check("t3_count", 32'(bus.Queue_Count), 32'd4);
        for (int i = 0; i < 4; i++) pop_check("t3_drain", 4'(i + 1), 32'h20 + 32'(i));
        check("t3_drained", 32'(bus.Issue_Valid), 32'd0);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("t3_ovf_flush", 32'(bus.Overflow_Err), 32'd1);

        // 4: steady flow at count 2 across pointer wrap
        push(4'h0, 5'd0, 32'h100);
        push(4'h1, 5'd0, 32'h101);
        for (int k = 0; k < 10; k++) begin
            check("t4_head", bus.Issue_Imm, 32'h100 + 32'(k));
            bus.Dispatch_en_Int = 1'b1;
            bus.Dispatch_Opcode = 4'(k + 2);
            bus.Dispatch_Imm_LS = 32'h100 + 32'(k + 2);
            bus.Issue_Ready = 1'b1;
            tick();
            check("t4_count", 32'(bus.Queue_Count), 32'd2);
        end
        bus.Dispatch_en_Int = 1'b0;
        bus.Issue_Ready = 1'b0;
        pop_check("t4_tail0", 4'hA, 32'h10A);
        pop_check("t4_tail1", 4'hB, 32'h10B);
        // Ready while empty must leave state alone
        bus.Issue_Ready = 1'b1;
        tick();
        bus.Issue_Ready = 1'b0;
        check("t4_empty_ready", 32'(bus.Queue_Count), 32'd0);

        // 5: flush with concurrent dispatch
        for (int i = 0; i < 3; i++) push(4'(i + 1), 5'd0, 32'h30 + 32'(i));
        Flush = 1'b1;
        bus.Dispatch_en_Int = 1'b1;
        bus.Dispatch_Opcode = 4'h5;
        tick();
        Flush = 1'b0;
        bus.Dispatch_en_Int = 1'b0;
        check("t5_count", 32'(bus.Queue_Count), 32'd0);
        check("t5_valid", 32'(bus.Issue_Valid), 32'd0);
        push(4'h7, 5'd0, 32'h77);
        check("t5_count1", 32'(bus.Queue_Count), 32'd1);
        pop_check("t5_first", 4'h7, 32'h77);

        // 6: reset beats flush and dispatch, clears sticky overflow
        for (int i = 0; i < 3; i++) push(4'(i + 1), 5'd1, 32'h40 + 32'(i));
        Rst = 1'b1;
        Flush = 1'b1;
        bus.Dispatch_en_Int = 1'b1;
        bus.Dispatch_Opcode = 4'h5;
        tick();
        Rst = 1'b0;
        Flush = 1'b0;
        bus.Dispatch_en_Int = 1'b0;
        check("t6_count", 32'(bus.Queue_Count), 32'd0);
        check("t6_full", 32'(bus.Queue_Full), 32'd0);
        check("t6_valid", 32'(bus.Issue_Valid), 32'd0);
        check("t6_op", 32'(bus.Issue_Opcode), 32'd0);
        check("t6_sh", 32'(bus.Issue_Shfamt), 32'd0);
        check("t6_imm", bus.Issue_Imm, 32'd0);
        check("t6_ovf", 32'(bus.Overflow_Err), 32'd0);
        push(4'h3, 5'd0, 32'h55);
        check("t6_count1", 32'(bus.Queue_Count), 32'd1);
        check("t6_op1", 32'(bus.Issue_Opcode), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Receiving end of the dispatch interface for the integer execution path.
- Captures every instruction the decode stage dispatches with Dispatch_en_Int asserted, holds it in an in-order FIFO, and issues it to the integer ALU over a valid/ready handshake.
- Reports full status back to dispatch so the decode stage can stall.
- Sits between the decoder and the integer ALU.

Parameters:
- DEPTH, 4: number of queue entries; power of two, minimum 2.
- PTR_W, 2: pointer width, equal to log2(DEPTH).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  reset, synchronous, active-high.
- Flush  input  1  synchronous clear of all queue contents (branch mispredict recovery).
- Dispatch_en_Int  input  1  dispatch write request.
- Dispatch_Opcode  input  4  ALU opcode: AND=0, OR=1, ADD=2, ADDU=3, BEQ=4, BNQ=5, SUB=6, SLT=7, SLL=8, SRL=9, SLTU=A, NOR=C.
- Dispatch_Shfamt  input  5  shift amount.
- Dispatch_Imm_LS  input  32  extended immediate.
- Queue_Full  output  1  combinational; high when count == DEPTH.
- Queue_Count  output  PTR_W+1  registered occupancy, 0..DEPTH.
- Issue_Valid  output  1  high when count != 0.
- Issue_Opcode  output  4  opcode of the head entry.
- Issue_Shfamt  output  5  shift amount of the head entry.
- Issue_Imm  output  32  immediate of the head entry.
- Issue_Ready  input  1  ALU accepts the head entry this cycle.
- Overflow_Err  output  1  sticky; set when a write is attempted while full.

Behaviour:
- Storage: DEPTH entries of {opcode[3:0], shfamt[4:0], imm[31:0]}, with wr_ptr, rd_ptr (PTR_W bits each) and count (PTR_W+1 bits).
- Write: accepted when Dispatch_en_Int=1 and count<DEPTH.
  - Entry stored at wr_ptr; wr_ptr increments modulo DEPTH.
  - Full is evaluated on the pre-edge count. A same-cycle pop does not make room for a write while full.
- Pop: occurs when Issue_Valid=1 and Issue_Ready=1; rd_ptr increments modulo DEPTH.
- Count update: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop (possible only when 0<count<DEPTH).
- Latency: an entry written at edge N is visible on Issue_* after edge N; no same-cycle bypass from an empty queue.
- Output timing: Issue_* are a combinational read of the entry at rd_ptr. When count==0, Issue_Opcode, Issue_Shfamt and Issue_Imm are driven to 0.
- Ordering: strict FIFO; entries issue in dispatch order.
- Dispatch while full:
  - Write dropped, contents unchanged.
  - Overflow_Err set to 1 and held until Rst. Flush does not clear it.
- Issue_Ready while empty: no effect; pointers and count are unchanged.
- Pointer wrap: ptr at DEPTH-1 increments to 0; count distinguishes full from empty.
- Flush=1 (Rst=0):
  - At the edge: wr_ptr=0, rd_ptr=0, count=0.
  - A dispatch write and a pop in the same cycle are both discarded.
  - Entry data need not be cleared.
- Rst=1 at the edge, with priority over Flush and all activity:
  - wr_ptr=0, rd_ptr=0, count=0, Overflow_Err=0.
  - Consequently Queue_Count=0, Queue_Full=0, Issue_Valid=0, Issue_Opcode=0, Issue_Shfamt=0, Issue_Imm=0.
  - Reset mid-operation discards all held entries.
- No state machine beyond the pointer/count FIFO.
- Assertions for the verification environment:
  - count <= DEPTH at all times.
  - wr_ptr - rd_ptr == count modulo DEPTH.

Test Plan:
1. Reset, then dispatch ADD (op=2, imm=0x00000005) in cycle 1 with Issue_Ready=0 -> after edge: Queue_Count=1, Issue_Valid=1, Issue_Opcode=2, Issue_Imm=0x00000005; Issue_Valid=0 in the cycle of the write itself.
2. Dispatch 4 entries (op 2, 6, 8 with shfamt=3, 9) with Issue_Ready=0 -> Queue_Full=1, Count=4. Raise Issue_Ready for 4 cycles -> issue order 2, 6, 8, 9; SLL entry shows Issue_Shfamt=3; Count ends at 0 and Issue_Valid=0.
3. With count=4, attempt a 5th dispatch (op=C) -> write dropped, Overflow_Err=1; drain yields exactly 4 entries, no op=C; Overflow_Err stays 1 after a Flush.
4. With count=2, simultaneous dispatch and Issue_Ready=1 for 10 cycles -> Count stays 2, pointers wrap past 3->0, and the issue sequence equals the dispatch sequence delayed by 2 entries.
5. With count=3, assert Flush together with Dispatch_en_Int=1 -> next cycle Count=0, Issue_Valid=0; the following dispatch (op=7) issues first.
6. With count=3, assert Rst together with Flush and dispatch -> all outputs 0 next cycle, including Overflow_Err; a subsequent single dispatch produces Count=1.
